// File: rtl/key_pkg.sv
// Shared constants and state encoding for the time-shared key debouncer.
package key_pkg;

  localparam logic [2:0] KS_SCAN   = 3'b001;
  localparam logic [2:0] KS_FILTER = 3'b010;
  localparam logic [2:0] KS_EMIT   = 3'b100;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  typedef enum logic [2:0] {
    ST_SCAN   = KS_SCAN,
    ST_FILTER = KS_FILTER,
    ST_EMIT   = KS_EMIT
  } key_fsm_e;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key pins; idles high like released keys.
module key_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture of the asynchronous pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {W{1'b1}};
      sync_r <= {W{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/key_debounce_sched.sv
// Round-robin debouncer: one shared counter filters whichever key currently
// disagrees with its debounced level, then reports the change as an event.
module key_debounce_sched
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int IDX_W           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDX_W-1:0]  evt_key,
  output logic              evt_press,
  output logic              busy
);

  logic [N_KEYS-1:0] ksync_s;

  key_fsm_e          state_r,     state_nxt_s;
  logic [IDX_W-1:0]  ptr_r,       ptr_nxt_s;
  logic [IDX_W-1:0]  sel_r,       sel_nxt_s;
  logic [CNT_W-1:0]  cnt_r,       cnt_nxt_s;
  logic [N_KEYS-1:0] key_state_r, key_state_nxt_s;
  logic              evt_valid_r, evt_valid_nxt_s;
  logic [IDX_W-1:0]  evt_key_r,   evt_key_nxt_s;
  logic              evt_press_r, evt_press_nxt_s;
  logic              busy_r,      busy_nxt_s;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Scan order wraps after the last implemented key, not at 2^IDX_W.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_KEYS - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return i + IDX_W'(1'b1);
    end
  endfunction

  key_sync #(.W(N_KEYS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (ksync_s)
  );

  // Next-state, scheduler and event logic.
  always_comb begin
    state_nxt_s     = state_r;
    ptr_nxt_s       = ptr_r;
    sel_nxt_s       = sel_r;
    cnt_nxt_s       = cnt_r;
    key_state_nxt_s = key_state_r;
    evt_valid_nxt_s = evt_valid_r;
    evt_key_nxt_s   = evt_key_r;
    evt_press_nxt_s = evt_press_r;

    case (state_r)
      ST_SCAN: begin
        if (ksync_s[ptr_r] != key_state_r[ptr_r]) begin
          sel_nxt_s   = ptr_r;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_FILTER;
        end else begin
          ptr_nxt_s = idx_next(ptr_r);
        end
      end
      ST_FILTER: begin
        // A level back at the debounced value wins over a same-cycle commit.
        if (ksync_s[sel_r] == key_state_r[sel_r]) begin
          state_nxt_s = ST_SCAN;
          ptr_nxt_s   = idx_next(sel_r);
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          key_state_nxt_s[sel_r] = ksync_s[sel_r];
          evt_key_nxt_s          = sel_r;
          evt_press_nxt_s        = (ksync_s[sel_r] == 1'b0) ? EVT_PRESS : EVT_RELEASE;
          evt_valid_nxt_s        = 1'b1;
          state_nxt_s            = ST_EMIT;
        end else if (cnt_r != CNT_MAX) begin
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_EMIT: begin
        if (evt_valid_r && evt_ready) begin
          evt_valid_nxt_s = 1'b0;
          ptr_nxt_s       = idx_next(sel_r);
          state_nxt_s     = ST_SCAN;
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: begin
        state_nxt_s     = ST_SCAN;
        ptr_nxt_s       = {IDX_W{1'b0}};
        cnt_nxt_s       = {CNT_W{1'b0}};
        evt_valid_nxt_s = 1'b0;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_SCAN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_SCAN;
      ptr_r       <= {IDX_W{1'b0}};
      sel_r       <= {IDX_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      key_state_r <= {N_KEYS{1'b1}};
      evt_valid_r <= 1'b0;
      evt_key_r   <= {IDX_W{1'b0}};
      evt_press_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      sel_r       <= sel_nxt_s;
      cnt_r       <= cnt_nxt_s;
      key_state_r <= key_state_nxt_s;
      evt_valid_r <= evt_valid_nxt_s;
      evt_key_r   <= evt_key_nxt_s;
      evt_press_r <= evt_press_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign key_state = key_state_r;
  assign evt_valid = evt_valid_r;
  assign evt_key   = evt_key_r;
  assign evt_press = evt_press_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_key_debounce_sched.sv
// Scenario bench for key_debounce_sched with a queue scoreboard of expected events.
module tb_key_debounce_sched;

  localparam int N_KEYS = 4;
  localparam int IDX_W  = 2;
  localparam int DB     = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_state;
  logic              evt_valid;
  logic              evt_ready;
  logic [IDX_W-1:0]  evt_key;
  logic              evt_press;
  logic              busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [2:0] exp_q[$];
  int hs_cyc_q[$];

  key_debounce_sched #(
    .N_KEYS(N_KEYS), .IDX_W(IDX_W), .DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(key_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_press(evt_press), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every accepted event must match the oldest expectation.
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL evt_unexpected: got key=%0d press=%0d, required no event", evt_key, evt_press);
      end else begin
        e = exp_q.pop_front();
        if ({evt_key, evt_press} !== e) begin
          fails = fails + 1;
          $display("FAIL evt_content: got key=%0d press=%0d, required key=%0d press=%0d",
                   evt_key, evt_press, e[2:1], e[0]);
        end
      end
      hs_cyc_q.push_back(cyc);
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    key_in    = 4'b1111;
    evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    key_in    = 4'b1111;
    evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks = checks + 5;
    if (key_state !== 4'b1111) begin fails++; $display("FAIL reset_key_state: got %b, required 1111", key_state); end
    if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_evt_valid: got %b, required 0", evt_valid); end
    if (evt_key !== 2'd0) begin fails++; $display("FAIL reset_evt_key: got %0d, required 0", evt_key); end
    if (evt_press !== 1'b0) begin fails++; $display("FAIL reset_evt_press: got %b, required 0", evt_press); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int n;
    bit found;
    do_reset();
    repeat (3) @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      exp_q.push_back({2'd2, (ph == 0) ? 1'b1 : 1'b0});
      key_in[2] = (ph == 0) ? 1'b0 : 1'b1;
      n = 0; found = 1'b0;
      while (n < 40 && !found) begin
        @(posedge clk); #1; n++;
        if (evt_valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || n < DB + 3 || n > DB + 6) begin
        fails++;
        $display("FAIL clean_latency_%0d: got found=%0d cycles=%0d, required %0d..%0d", ph, found, n, DB + 3, DB + 6);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (key_state !== ((ph == 0) ? 4'b1011 : 4'b1111)) begin
        fails++;
        $display("FAIL clean_key_state_%0d: got %b, required %b", ph, key_state, (ph == 0) ? 4'b1011 : 4'b1111);
      end
      repeat (20) @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL clean_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    int n;
    bit found;
    do_reset();
    hs_cyc_q.delete();
    for (int i = 0; i < 6; i++) begin
      key_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) @(negedge clk);
    end
    checks++;
    if (hs_cyc_q.size() != 0) begin fails++; $display("FAIL bounce_quiet: got %0d events, required 0", hs_cyc_q.size()); end
    exp_q.push_back({2'd1, 1'b1});
    key_in[1] = 1'b0;
    n = 0; found = 1'b0;
    while (n < 60 && !found) begin
      @(posedge clk); #1; n++;
      if (evt_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || n < DB + 3 || n > DB + 6) begin
      fails++;
      $display("FAIL bounce_latency: got found=%0d cycles=%0d, required %0d..%0d", found, n, DB + 3, DB + 6);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (hs_cyc_q.size() != 1 || key_state !== 4'b1101) begin
      fails++;
      $display("FAIL bounce_result: got events=%0d key_state=%b, required 1 and 1101", hs_cyc_q.size(), key_state);
    end
    exp_q.push_back({2'd1, 1'b0});
    key_in[1] = 1'b1;
    n = 0;
    while (n < 60 && exp_q.size() != 0) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL bounce_release: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    bit saw_busy;
    do_reset();
    @(negedge clk);
    saw_busy = 1'b0;
    key_in[0] = 1'b0;
    repeat (10) begin @(negedge clk); if (busy === 1'b1) saw_busy = 1'b1; end
    key_in[0] = 1'b1;
    repeat (30) @(negedge clk);
    checks = checks + 3;
    if (saw_busy !== 1'b1) begin fails++; $display("FAIL glitch_filter_entered: got busy_seen=%0d, required 1", saw_busy); end
    if (key_state !== 4'b1111) begin fails++; $display("FAIL glitch_key_state: got %b, required 1111", key_state); end
    if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b, required 0", busy); end
  endtask

  task automatic test_simultaneous();
    int n;
    rst_n = 1'b0; key_in = 4'b1111; evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    hs_cyc_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 1'b1});
    key_in = 4'b0000;
    n = 0;
    while (n < 200 && exp_q.size() != 0) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL simul_drain: got %0d pending, required 0", exp_q.size()); end
    checks++;
    if (hs_cyc_q.size() != 4) begin
      fails++; $display("FAIL simul_count: got %0d events, required 4", hs_cyc_q.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (hs_cyc_q[k] - hs_cyc_q[k-1] < DB + 1 || hs_cyc_q[k] - hs_cyc_q[k-1] > DB + 2) begin
          fails++;
          $display("FAIL simul_spacing_%0d: got %0d cycles, required %0d..%0d", k, hs_cyc_q[k] - hs_cyc_q[k-1], DB + 1, DB + 2);
        end
      end
    end
    checks++;
    if (key_state !== 4'b0000) begin fails++; $display("FAIL simul_key_state: got %b, required 0000", key_state); end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    logic [1:0] k0;
    logic p0;
    do_reset();
    evt_ready = 1'b0;
    @(negedge clk);
    exp_q.push_back({2'd3, 1'b1});
    key_in[3] = 1'b0;
    repeat (8) @(negedge clk);
    exp_q.push_back({2'd1, 1'b1});
    key_in[1] = 1'b0;
    n = 0;
    while (n < 60 && evt_valid !== 1'b1) begin @(posedge clk); #1; n++; end
    checks++;
    if (evt_valid !== 1'b1 || evt_key !== 2'd3 || evt_press !== 1'b1) begin
      fails++;
      $display("FAIL bp_first: got valid=%b key=%0d press=%b, required 1 3 1", evt_valid, evt_key, evt_press);
    end
    k0 = evt_key; p0 = evt_press; bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (evt_valid !== 1'b1 || evt_key !== k0 || evt_press !== p0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable cycles, required 0", bad); end
    @(negedge clk);
    evt_ready = 1'b1;
    n = 0;
    while (n < 100 && exp_q.size() != 0) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || key_state !== 4'b0101) begin
      fails++;
      $display("FAIL bp_result: got pending=%0d key_state=%b, required 0 and 0101", exp_q.size(), key_state);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    @(negedge clk);
    key_in[2] = 1'b0;
    n = 0;
    while (n < 20 && busy !== 1'b1) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || key_state !== 4'b1111 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got valid=%b key_state=%b busy=%b, required 0 1111 0", evt_valid, key_state, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({2'd2, 1'b1});
    n = 0;
    while (n < 60 && evt_valid !== 1'b1) begin @(posedge clk); #1; n++; end
    checks++;
    if (evt_valid !== 1'b1 || n < DB + 1 || n > DB + 6) begin
      fails++;
      $display("FAIL midreset_press_latency: got valid=%b cycles=%0d, required 1 and %0d..%0d", evt_valid, n, DB + 1, DB + 6);
    end
    repeat (3) @(negedge clk);
    exp_q.push_back({2'd2, 1'b0});
    key_in[2] = 1'b1;
    n = 0;
    while (n < 60 && exp_q.size() != 0) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL midreset_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL final_drain: got %0d pending, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce_sched.md
Name: key_debounce_sched

Overview:
- Time-shares one debounce counter across N_KEYS active-low push buttons.
- Round-robin scheduler: finds a key whose synchronized level differs from its debounced state, then filters it for DEBOUNCE_CYCLES.
- On a confirmed change it commits the new debounced state and issues one press or release event on a valid/ready interface.
- Sits between the board key pins and the front-panel / menu control logic; replaces per-key counter instances.

Parameters:
- N_KEYS, 4, number of key inputs (2..16)
- IDX_W, 2, width of the key index; must equal clog2(N_KEYS)
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a change (20 ms at 50 MHz)
- CNT_W, 20, width of the shared counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_in  in  N_KEYS  raw key pins, asynchronous, 0 = pressed, idle 1
- key_state  out  N_KEYS  debounced level per key, 0 = held down
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_key  out  IDX_W  index of the key that changed
- evt_press  out  1  1 = press (1->0), 0 = release (0->1)
- busy  out  1  high in FILTER or EMIT

Behaviour:
- Reset (async, rst_n=0):
  - synchronizer flops = all 1; key_state = all 1.
  - evt_valid = 0, evt_key = 0, evt_press = 0, busy = 0.
  - ptr = 0, cnt = 0, state = SCAN.
- Synchronization: key_in passes through 2 flops per bit; ksync = second stage. The FSM sees only ksync, so input-to-ksync latency is 2 cycles.
- FSM states, one-hot: SCAN, FILTER, EMIT.
- SCAN:
  - Each cycle examines key ptr.
  - If ksync[ptr] != key_state[ptr]: sel <= ptr, cnt <= 0, go FILTER.
  - Otherwise ptr <= ptr+1, wrapping N_KEYS-1 -> 0.
- FILTER:
  - cnt increments every cycle.
  - Abort when ksync[sel] == key_state[sel]: go SCAN, ptr <= sel+1 (wrap), cnt <= 0. No event, key_state unchanged.
  - Commit when cnt == DEBOUNCE_CYCLES-1 and the input still differs:
    - key_state[sel] <= ksync[sel];
    - evt_key <= sel; evt_press <= ~ksync[sel]; evt_valid <= 1;
    - go EMIT.
  - Abort has priority over commit in the same cycle.
  - Commit takes effect exactly DEBOUNCE_CYCLES edges after the FILTER-entry edge.
- EMIT:
  - evt_valid, evt_key and evt_press hold stable until evt_valid && evt_ready.
  - On handshake: evt_valid <= 0, ptr <= sel+1 (wrap), go SCAN.
  - Other keys are not serviced while stalled; their changes are picked up later, since SCAN compares levels rather than edges.
- Events:
  - Edges shorter than the filter window never produce events.
  - A press followed by a release always yields two events in order.
  - A key that toggles an even number of times while waiting unserviced yields no event.
- busy = state != SCAN, registered.
- cnt saturates: it never wraps and is cleared on every FILTER entry.
- Reset asserted mid-FILTER or mid-EMIT: any pending event is lost; after release, keys still held are reported as fresh presses after DEBOUNCE_CYCLES.
- Worst-case detection latency for one key: 2 + N_KEYS + (N_KEYS-1)*(DEBOUNCE_CYCLES+1) + DEBOUNCE_CYCLES cycles, with evt_ready tied high.

Decomposition:
- Package key_pkg holds:
  - state localparams KS_SCAN = 3'b001, KS_FILTER = 3'b010, KS_EMIT = 3'b100;
  - default DEBOUNCE_CYCLES = 1000000;
  - EVT_PRESS = 1'b1, EVT_RELEASE = 1'b0.
- Sub-module key_sync: parameterized-width 2-flop synchronizer, reset value all 1. The FSM, counter and pointer stay in the top module.

Test Plan:
- Setup for all scenarios: N_KEYS=4, DEBOUNCE_CYCLES=16, evt_ready=1 unless stated.
- Clean press: key_in[2] 1->0, held 40 cycles -> key_state[2]=0 and one event {evt_key=2, evt_press=1} 2+(<=4)+16 cycles after the edge; a clean release later gives {2, 0}.
- Bounce: key_in[1] toggles low/high every 5 cycles for 30 cycles, then settles low -> no event during bouncing; exactly one press event 16 cycles after settling is seen in FILTER.
- Glitch: key_in[0] low for 10 cycles, then high -> no event, key_state=4'b1111, busy returns to 0.
- Simultaneous: key_in = 4'b0000 at once -> four press events ordered 0,1,2,3, each ~17 cycles apart; key_state ends at 0000.
- Backpressure: evt_ready=0 during a key 3 press; key 1 is pressed meanwhile -> key 3 event holds stable for 50 cycles; after evt_ready=1, key 1's event follows; no loss.
- Reset mid-operation: rst_n pulsed low while in FILTER on key 2 -> outputs return to reset values immediately (evt_valid=0, key_state=1111); the held key reports a press 16+ cycles after release.
